pipeline_run_ctrl: RTL and testbench

//  Parametrised run/halt controller for the N-stage MIPS pipeline; drives the global freeze (o_halt) to every stage.

---
 rtl/pipeline_run_ctrl_pkg.sv | 23 ++
 rtl/pipeline_run_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctrl_pkg
// Description : Shared state and run-mode encodings for the pipeline run/halt
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_run_ctrl_pkg;

    // Controller state encodings (visible on o_state)
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_run   = 3'd1;
    localparam logic [2:0] c_st_step  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Run modes sampled with i_start; 2'b11 behaves as continuous
    localparam logic [1:0] c_mode_cont = 2'b00;
    localparam logic [1:0] c_mode_step = 2'b01;
    localparam logic [1:0] c_mode_runn = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc until all-ones; clear has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctrl
// Description : Run/halt controller for the N-stage pipeline. Drives the global
//               freeze, supports continuous / single-step / run-N modes and a
//               HALT-instruction drain, and keeps saturating cycle and retired
//               instruction counters.
//               Optional feature macro: PIPE_CTRL_BREAKPOINT_EN enables the
//               PC breakpoint compare against the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_step,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_run_count,
    input  logic             i_halt_instr,
    input  logic             i_wb_valid,
    input  logic             i_clear,
    input  logic             i_bp_valid,
    input  logic [PC_W-1:0]  i_bp_addr,
    input  logic [PC_W-1:0]  i_pc_id,
    output logic             o_halt,
    output logic             o_fetch_stop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_bp_hit,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instr_cnt
);

    // Drain covers the instructions already past IF: ID through WB
    localparam int                 DRAIN_W     = $clog2(NUM_STAGES);
    localparam logic [DRAIN_W-1:0] c_drain_len = DRAIN_W'(NUM_STAGES - 2);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_run_left;
    logic               r_run_n;
    logic [DRAIN_W-1:0] r_drain_left;
    logic               r_bp_hit;

    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_run_left_nxt;
    logic               w_run_n_nxt;
    logic [DRAIN_W-1:0] w_drain_left_nxt;
    logic               w_bp_set;
    logic               w_bp_match;
    logic               w_adv;

`ifdef PIPE_CTRL_BREAKPOINT_EN
    assign w_bp_match = i_bp_valid && (i_pc_id == i_bp_addr);
`else
    // Breakpoint ports exist for interface compatibility but have no effect
    logic w_unused_bp;
    assign w_unused_bp = ^{i_bp_valid, i_bp_addr, i_pc_id};
    assign w_bp_match  = 1'b0;
`endif

    // The pipeline advances only in the RUN, STEP and DRAIN states
    assign w_adv = (r_state == c_st_run) || (r_state == c_st_step) || (r_state == c_st_drain);

    // Next-state decode with run-N and drain bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_run_left_nxt   = r_run_left;
        w_run_n_nxt      = r_run_n;
        w_drain_left_nxt = r_drain_left;
        w_bp_set         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    case (i_mode)
                        c_mode_step: w_state_nxt = c_st_step;
                        c_mode_runn: begin
                            // A zero-length run-N request is a no-op
                            if (i_run_count != '0) begin
                                w_state_nxt    = c_st_run;
                                w_run_n_nxt    = 1'b1;
                                w_run_left_nxt = i_run_count;
                            end
                        end
                        default: begin
                            w_state_nxt = c_st_run;
                            w_run_n_nxt = 1'b0;
                        end
                    endcase
                end else if (i_step) begin
                    w_state_nxt = c_st_step;
                end
            end
            c_st_run: begin
                if (r_run_n) begin
                    w_run_left_nxt = r_run_left - 1'b1;
                end
                if (i_halt_instr) begin
                    w_state_nxt      = c_st_drain;
                    w_drain_left_nxt = c_drain_len;
                end else if (w_bp_match) begin
                    w_state_nxt = c_st_idle;
                    w_bp_set    = 1'b1;
                end else if (i_stop) begin
                    w_state_nxt = c_st_idle;
                end else if (r_run_n && (r_run_left == CNT_W'(1))) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_step: begin
                w_state_nxt = c_st_idle;
                if (i_halt_instr) begin
                    w_state_nxt      = c_st_drain;
                    w_drain_left_nxt = c_drain_len;
                end else if (w_bp_match) begin
                    w_bp_set = 1'b1;
                end
            end
            c_st_drain: begin
                w_drain_left_nxt = r_drain_left - 1'b1;
                if (r_drain_left <= DRAIN_W'(1)) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (i_clear) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Controller state registers and sticky breakpoint flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= c_st_idle;
            r_run_left   <= '0;
            r_run_n      <= 1'b0;
            r_drain_left <= '0;
            r_bp_hit     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_left   <= w_run_left_nxt;
            r_run_n      <= w_run_n_nxt;
            r_drain_left <= w_drain_left_nxt;
            if (i_clear || ((r_state == c_st_idle) && i_start)) begin
                r_bp_hit <= 1'b0;
            end else if (w_bp_set) begin
                r_bp_hit <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_inc   (w_adv),
        .i_clr   (i_clear),
        .o_count (o_cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_inc   (w_adv && i_wb_valid),
        .i_clr   (i_clear),
        .o_count (o_instr_cnt)
    );

    assign o_halt       = !w_adv;
    assign o_busy       = w_adv;
    assign o_done       = (r_state == c_st_done);
    assign o_fetch_stop = (r_state == c_st_drain) || (w_adv && i_halt_instr);
    assign o_bp_hit     = r_bp_hit;
    assign o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_run_ctrl
// Description : Self-checking bench for pipeline_run_ctrl (4-bit counters so
//               saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset, start, step, stop, halt_instr, wb_valid, clear, bp_valid;
    logic [1:0]          mode;
    logic [TB_CNT_W-1:0] run_count;
    logic [31:0]         bp_addr, pc_id;
    logic                halt, fetch_stop, busy, done, bp_hit;
    logic [2:0]          state;
    logic [TB_CNT_W-1:0] cycle_cnt, instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {o_halt, o_done} after each clock edge
    logic [1:0] exp_q[$];

    pipeline_run_ctrl #(.NUM_STAGES(5), .CNT_W(TB_CNT_W), .PC_W(32)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_mode       (mode),
        .i_step       (step),
        .i_stop       (stop),
        .i_run_count  (run_count),
        .i_halt_instr (halt_instr),
        .i_wb_valid   (wb_valid),
        .i_clear      (clear),
        .i_bp_valid   (bp_valid),
        .i_bp_addr    (bp_addr),
        .i_pc_id      (pc_id),
        .o_halt       (halt),
        .o_fetch_stop (fetch_stop),
        .o_busy       (busy),
        .o_done       (done),
        .o_bp_hit     (bp_hit),
        .o_state      (state),
        .o_cycle_cnt  (cycle_cnt),
        .o_instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expectation for the state after the next edge, then clock
    task automatic tick(input logic [1:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare one expectation per cycle
    always @(negedge clk) begin
        logic [1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("halt", {31'd0, halt}, {31'd0, e[1]});
            check("done", {31'd0, done}, {31'd0, e[0]});
            check("busy", {31'd0, busy}, {31'd0, !e[1]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b1; mode = 2'b00; step = 1'b0; stop = 1'b0;
        run_count = '0; halt_instr = 1'b0; wb_valid = 1'b0; clear = 1'b0;
        bp_valid = 1'b0; bp_addr = 32'h0; pc_id = 32'h0;

        // Reset held with i_start high stays idle
        tick(2'b10); tick(2'b10);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_cyc", {28'd0, cycle_cnt}, 32'd0);
        check("rst_instr", {28'd0, instr_cnt}, 32'd0);
        check("rst_fstop", {31'd0, fetch_stop}, 32'd0);
        check("rst_bp", {31'd0, bp_hit}, 32'd0);
        reset = 1'b0; start = 1'b0;
        tick(2'b10);

        // Run-N for 7 cycles; retire every advancing cycle
        wb_valid = 1'b1; mode = 2'b10; run_count = 4'd7; start = 1'b1;
        tick(2'b00); start = 1'b0;
        repeat (6) tick(2'b00);
        tick(2'b10); tick(2'b10);
        check("runn_cyc", {28'd0, cycle_cnt}, 32'd7);
        check("runn_instr", {28'd0, instr_cnt}, 32'd7);
        check("runn_state", {29'd0, state}, 32'd0);

        clear = 1'b1; tick(2'b10); clear = 1'b0;
        check("clr_cyc", {28'd0, cycle_cnt}, 32'd0);
        check("clr_instr", {28'd0, instr_cnt}, 32'd0);

        // Run-N with zero count does not start
        run_count = 4'd0; start = 1'b1; tick(2'b10); start = 1'b0; tick(2'b10);
        check("runn0_cyc", {28'd0, cycle_cnt}, 32'd0);

        // Three single steps, four cycles apart
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(2'b00);
            check("step_state", {29'd0, state}, 32'd2);
            step = 1'b0; tick(2'b10); tick(2'b10); tick(2'b10);
        end
        check("step_cyc", {28'd0, cycle_cnt}, 32'd3);
        check("step_instr", {28'd0, instr_cnt}, 32'd3);

        // i_start beats i_step
        clear = 1'b1; tick(2'b10); clear = 1'b0;
        mode = 2'b00; start = 1'b1; step = 1'b1; tick(2'b00);
        start = 1'b0; step = 1'b0; tick(2'b00);
        stop = 1'b1; tick(2'b10); stop = 1'b0;
        check("prio_cyc", {28'd0, cycle_cnt}, 32'd2);

        // HALT instruction at run cycle 10 then 3-cycle drain
        clear = 1'b1; tick(2'b10); clear = 1'b0;
        start = 1'b1; tick(2'b00); start = 1'b0;
        repeat (9) tick(2'b00);
        check("run_fstop", {31'd0, fetch_stop}, 32'd0);
        halt_instr = 1'b1; #1;
        check("halt_fstop", {31'd0, fetch_stop}, 32'd1);
        tick(2'b00); halt_instr = 1'b0;
        check("drain_state", {29'd0, state}, 32'd3);
        check("drain_fstop", {31'd0, fetch_stop}, 32'd1);
        tick(2'b00); tick(2'b00); tick(2'b11);
        check("done_state", {29'd0, state}, 32'd4);
        check("done_cyc", {28'd0, cycle_cnt}, 32'd13);
        check("done_instr", {28'd0, instr_cnt}, 32'd13);
        start = 1'b1; step = 1'b1; tick(2'b11); tick(2'b11); start = 1'b0; step = 1'b0;
        check("done_sticky_cyc", {28'd0, cycle_cnt}, 32'd13);
        clear = 1'b1; tick(2'b10); clear = 1'b0;
        check("done_clr_state", {29'd0, state}, 32'd0);
        check("done_clr_cyc", {28'd0, cycle_cnt}, 32'd0);

        // Breakpoint on PC 0x40 at run cycle 5
        bp_valid = 1'b1; bp_addr = 32'h40; pc_id = 32'h0;
        start = 1'b1; tick(2'b00); start = 1'b0;
        repeat (4) tick(2'b00);
        pc_id = 32'h40;
`ifdef PIPE_CTRL_BREAKPOINT_EN
        tick(2'b10); pc_id = 32'h0;
        check("bp_hit", {31'd0, bp_hit}, 32'd1);
        check("bp_state", {29'd0, state}, 32'd0);
        start = 1'b1; tick(2'b00); start = 1'b0;
        check("bp_restart_clr", {31'd0, bp_hit}, 32'd0);
        stop = 1'b1; tick(2'b10); stop = 1'b0;
`else
        tick(2'b00); pc_id = 32'h0;
        check("bp_off_hit", {31'd0, bp_hit}, 32'd0);
        check("bp_off_state", {29'd0, state}, 32'd1);
        stop = 1'b1; tick(2'b10); stop = 1'b0;
`endif
        bp_valid = 1'b0;

        // Counter saturation after 20 advancing cycles
        clear = 1'b1; tick(2'b10); clear = 1'b0;
        start = 1'b1; tick(2'b00); start = 1'b0;
        repeat (19) tick(2'b00);
        stop = 1'b1; tick(2'b10); stop = 1'b0;
        check("sat_cyc", {28'd0, cycle_cnt}, 32'd15);
        check("sat_instr", {28'd0, instr_cnt}, 32'd15);
        clear = 1'b1; tick(2'b10); clear = 1'b0;
        check("sat_clr", {28'd0, cycle_cnt}, 32'd0);

        // Reset in the middle of a drain
        start = 1'b1; tick(2'b00); start = 1'b0;
        halt_instr = 1'b1; tick(2'b00); halt_instr = 1'b0;
        check("rstd_drain", {29'd0, state}, 32'd3);
        reset = 1'b1; tick(2'b10); reset = 1'b0;
        check("rstd_state", {29'd0, state}, 32'd0);
        check("rstd_cyc", {28'd0, cycle_cnt}, 32'd0);
        tick(2'b10);

        @(negedge clk); #1;
        check("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
